button_events: RTL and testbench

Parametrised multi-channel button front end. It generalises the single-button release detector. For each of N_BTN raw push-button inputs it synchronises, debounces, and classifies presses into single-cycle event pulses: press, release, short click, long press, and auto-repeat while held. It sits between the board pins and the control FSMs, which consume only one-cycle pulses and a clean level.

---
 rtl/button_pkg.sv | 18 +
 rtl/button_channel.sv | 118 +++++++++++
 rtl/button_events.sv | 42 ++++
 tb/tb_button_events.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared FSM state, event bundle and counter-width helper for the button front end.
package button_pkg;

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

    typedef struct packed {
        logic press;
        logic rel;
        logic click;
        logic lng;
        logic rpt;
    } ev_t;

    function automatic int cnt_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one button bit -- synchroniser, debouncer and press/long/repeat classifier.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 100_000_000,
    parameter int REPEAT_CYC   = 20_000_000,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int   DW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int   HW  = cnt_w(LONG_CYC, REPEAT_CYC);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [1:0]    sync_q;
    logic          sync_n;
    logic          stable_q, stable_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_done;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          level_q;
    ev_t           ev_q, ev_d;

    assign sync_n  = sync_q[1] ^ POL;
    assign db_done = (db_cnt_q == DW'(DEBOUNCE_CYC - 1));

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync_n != stable_q) begin
            stable_d = db_done ? ~stable_q : stable_q;
            db_cnt_d = db_done ? '0 : db_cnt_q + 1'b1;
        end
    end

    // A release seen on a threshold cycle takes priority over long/repeat.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ev_d       = '0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = stable_q ? HW'(1) : '0;
                state_d    = stable_q ? HELD : IDLE;
                ev_d.press = stable_q;
            end
            HELD: begin
                if (!stable_q) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    ev_d.rel   = 1'b1;
                    ev_d.click = 1'b1;
                end else if (hold_cnt_q == HW'(LONG_CYC)) begin
                    state_d    = LONG;
                    hold_cnt_d = HW'(1);
                    ev_d.lng   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!stable_q) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    ev_d.rel   = 1'b1;
                end else if (hold_cnt_q == HW'(REPEAT_CYC)) begin
                    hold_cnt_d = HW'(1);
                    ev_d.rpt   = repeat_en;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync_q     <= {2{POL}};
            stable_q   <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            ev_q       <= '0;
        end else begin
            sync_q     <= {sync_q[0], btn_in};
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= stable_q;
            ev_q       <= ev_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = ev_q.press;
    assign release_o = ev_q.rel;
    assign click_o   = ev_q.click;
    assign long_o    = ev_q.lng;
    assign repeat_o  = ev_q.rpt;

endmodule

// File: rtl/button_events.sv
// button_events: N independent debounced button channels emitting one-cycle event pulses.
module button_events
    import button_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 100_000_000,
    parameter int REPEAT_CYC   = 20_000_000,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] click_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] repeat_o
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk_sys  (clk_sys),
            .rst      (rst),
            .btn_in   (btn_in[i]),
            .repeat_en(repeat_en[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i]),
            .click_o  (click_o[i]),
            .long_o   (long_o[i]),
            .repeat_o (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed and random stimulus on active-high and active-low instances against a timeline model.
module tb_button_events;
    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk_sys = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_in_n;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level_o, press_o, release_o, click_o, long_o, repeat_o;
    logic [N-1:0] al_level, al_press, al_release, al_click, al_long, al_repeat;

    assign btn_in_n = ~btn_in;

    always #5 clk_sys = ~clk_sys;

    button_events #(.N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .ACTIVE_LOW(0)) dut (
        .clk_sys(clk_sys), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .click_o(click_o), .long_o(long_o), .repeat_o(repeat_o)
    );

    button_events #(.N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .ACTIVE_LOW(1)) dut_n (
        .clk_sys(clk_sys), .rst(rst), .btn_in(btn_in_n), .repeat_en(repeat_en),
        .level_o(al_level), .press_o(al_press), .release_o(al_release),
        .click_o(al_click), .long_o(al_long), .repeat_o(al_repeat)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: pipeline of two samples, a level accepted after D consecutive differing
    // samples, and event timing derived from the age of the current press.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_pressed;
    int m_run[N];
    int m_age[N];
    logic [N-1:0] e_level, e_press, e_rel, e_click, e_long, e_rep;

    int n_press[N], n_rel[N], n_click[N], n_long[N], n_rep[N];
    int t_press[N], t_rel[N], t_click[N], t_long[N], t_rep[N];
    logic [N-1:0] lvl_seen, first_press;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pressed = '0;
        e_level = '0; e_press = '0; e_rel = '0; e_click = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0;
            m_age[c] = 0;
        end
    endtask

    task automatic model_step();
        int a;
        for (int c = 0; c < N; c++) begin
            e_level[c] = m_lvl[c];
            e_press[c] = 1'b0; e_rel[c] = 1'b0; e_click[c] = 1'b0;
            e_long[c] = 1'b0; e_rep[c] = 1'b0;
            if (!m_pressed[c]) begin
                if (m_lvl[c]) begin
                    e_press[c] = 1'b1;
                    m_pressed[c] = 1'b1;
                    m_age[c] = 0;
                end
            end else begin
                a = m_age[c] + 1;
                if (!m_lvl[c]) begin
                    e_rel[c] = 1'b1;
                    e_click[c] = (a <= L);
                    m_pressed[c] = 1'b0;
                end else begin
                    e_long[c] = (a == L);
                    e_rep[c] = repeat_en[c] && (a > L) && ((a - L) % R == 0);
                    m_age[c] = a;
                end
            end
            if (m_s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_in[c];
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("level", level_o, e_level);
        chk("press", press_o, e_press);
        chk("release", release_o, e_rel);
        chk("click", click_o, e_click);
        chk("long", long_o, e_long);
        chk("repeat", repeat_o, e_rep);
        chk("al_level", al_level, e_level);
        chk("al_press", al_press, e_press);
        chk("al_release", al_release, e_rel);
        chk("al_click", al_click, e_click);
        chk("al_long", al_long, e_long);
        chk("al_repeat", al_repeat, e_rep);
    endtask

    task automatic clr_stats();
        lvl_seen = '0;
        first_press = '0;
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_click[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            t_press[c] = -1; t_rel[c] = -1; t_click[c] = -1; t_long[c] = -1; t_rep[c] = -1;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            if (!rst) model_step();
            @(negedge clk_sys);
            cyc++;
            check_all();
            lvl_seen |= level_o;
            if (first_press == '0) first_press = press_o;
            for (int c = 0; c < N; c++) begin
                if (press_o[c]) begin n_press[c]++; if (t_press[c] < 0) t_press[c] = cyc; end
                if (release_o[c]) begin n_rel[c]++; if (t_rel[c] < 0) t_rel[c] = cyc; end
                if (click_o[c]) begin n_click[c]++; if (t_click[c] < 0) t_click[c] = cyc; end
                if (long_o[c]) begin n_long[c]++; if (t_long[c] < 0) t_long[c] = cyc; end
                if (repeat_o[c]) begin n_rep[c]++; if (t_rep[c] < 0) t_rep[c] = cyc; end
            end
        end
    endtask

    initial begin
        int t0, t1;
        model_reset();
        clr_stats();
        step(3);
        rst = 1'b0;
        step(5);

        clr_stats();
        btn_in[0] = 1'b1;
        step(3);
        btn_in[0] = 1'b0;
        step(15);
        chk_int("glitch_press", n_press[0], 0);
        chk_int("glitch_level", int'(lvl_seen[0]), 0);

        clr_stats();
        t0 = cyc;
        btn_in[0] = 1'b1;
        step(10);
        t1 = cyc;
        btn_in[0] = 1'b0;
        step(15);
        chk_int("click_press_lat", t_press[0] - t0, 7);
        chk_int("click_release_lat", t_rel[0] - t1, 7);
        chk_int("click_coincident", t_click[0], t_rel[0]);
        chk_int("click_count", n_click[0], 1);
        chk_int("click_no_long", n_long[0], 0);

        clr_stats();
        repeat_en = 2'b10;
        btn_in[1] = 1'b1;
        step(60);
        btn_in[1] = 1'b0;
        step(15);
        chk_int("long_lat", t_long[1] - t_press[1], L);
        chk_int("long_count", n_long[1], 1);
        chk_int("repeat_first", t_rep[1] - t_long[1], R);
        chk_int("repeat_count", n_rep[1], 4);
        chk_int("long_release", n_rel[1], 1);
        chk_int("long_no_click", n_click[1], 0);

        clr_stats();
        repeat_en = 2'b00;
        btn_in[1] = 1'b1;
        step(60);
        btn_in[1] = 1'b0;
        step(15);
        chk_int("norep_long", n_long[1], 1);
        chk_int("norep_repeat", n_rep[1], 0);

        clr_stats();
        btn_in = 2'b11;
        step(10);
        chk("simul_press", first_press, 2'b11);
        btn_in = 2'b00;
        step(15);

        clr_stats();
        btn_in[0] = 1'b1;
        step(16);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_level", level_o, '0);
        step(1);
        rst = 1'b0;
        clr_stats();
        t0 = cyc;
        step(12);
        chk_int("rst_press_lat", t_press[0] - t0, 7);
        chk_int("rst_no_release", n_rel[0], 0);
        btn_in[0] = 1'b0;
        step(15);

        for (int k = 0; k < 300; k++) begin
            btn_in = N'($urandom);
            repeat_en = N'($urandom);
            step(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45));
        end
        btn_in = '0;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
